// File: rtl/serial_tx_10bit.sv
// serial_tx_10bit: valid/ready word in, start/data/stop serial frame out, each bit held CLKS_PER_BIT clocks.
module serial_tx_10bit #(
    parameter int DATA_W       = 10,
    parameter int CLKS_PER_BIT = 4,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              last_clk;
    logic              first_bit;
    logic              next_bit;

    // The outgoing bit always sits at the shift register's exit end.
    always_comb begin
        last_clk  = cnt_q == CW'(CLKS_PER_BIT - 1);
        sh_d      = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
        first_bit = MSB_FIRST ? sh_q[DATA_W-1] : sh_q[0];
        next_bit  = MSB_FIRST ? sh_d[DATA_W-1] : sh_d[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        sh_q    <= din;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    cnt_q <= last_clk ? '0 : cnt_q + 1'b1;
                    if (last_clk) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= first_bit;
                    end
                end
                DATA: begin
                    cnt_q <= last_clk ? '0 : cnt_q + 1'b1;
                    if (last_clk) begin
                        if (bit_q == BW'(DATA_W - 1)) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            sh_q  <= sh_d;
                            tx_q  <= next_bit;
                        end
                    end
                end
                STOP: begin
                    cnt_q <= last_clk ? '0 : cnt_q + 1'b1;
                    if (last_clk) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign din_ready = state_q == IDLE;
    assign tx_out    = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_serial_tx_10bit.sv
// tb_serial_tx_10bit: two instances (LSB-first C=4, MSB-first C=1) checked every cycle
// against a frame-position model, plus literal frame checks for the directed scenarios.
module tb_serial_tx_10bit;
    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] din_a  [2];
    logic       val_a  [2];
    logic       rdy_a  [2];
    logic       tx_a   [2];
    logic       busy_a [2];
    logic       done_a [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int         m_pos  [2] = '{-1, -1};
    logic [9:0] m_dat  [2] = '{10'h0, 10'h0};
    logic       m_done [2] = '{1'b0, 1'b0};

    logic rtx [2][128];
    logic rdn [2][128];
    logic rbs [2][128];

    always #5 clk = ~clk;

    serial_tx_10bit #(.DATA_W(10), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .din(din_a[0]), .din_valid(val_a[0]),
        .din_ready(rdy_a[0]), .tx_out(tx_a[0]), .busy(busy_a[0]), .done(done_a[0])
    );

    serial_tx_10bit #(.DATA_W(10), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) dut2 (
        .clk(clk), .reset(reset), .din(din_a[1]), .din_valid(val_a[1]),
        .din_ready(rdy_a[1]), .tx_out(tx_a[1]), .busy(busy_a[1]), .done(done_a[1])
    );

    function automatic int cpb(input int u);
        return (u == 1) ? 1 : 4;
    endfunction

    // Frame slot idx: 0 = start, 1..10 = data bits in line order, 11 = stop.
    function automatic logic fbit(input logic [9:0] d, input int idx, input bit msb);
        if (idx == 0) return 1'b0;
        if (idx == 11) return 1'b1;
        return msb ? d[10-idx] : d[idx-1];
    endfunction

    function automatic int npos(input int u);
        if (reset) return -1;
        if (m_pos[u] < 0) return val_a[u] ? 0 : -1;
        if (m_pos[u] + 1 == 12 * cpb(u)) return -1;
        return m_pos[u] + 1;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            m_pos[u]  <= npos(u);
            m_done[u] <= !reset && m_pos[u] >= 0 && m_pos[u] + 1 == 12 * cpb(u);
            if (!reset && m_pos[u] < 0 && val_a[u]) m_dat[u] <= din_a[u];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                check($sformatf("model_tx%0d", u), 32'(tx_a[u]),
                      32'(m_pos[u] < 0 ? 1'b1 : fbit(m_dat[u], m_pos[u] / cpb(u), u == 1)));
                check($sformatf("model_busy%0d", u), 32'(busy_a[u]), 32'(m_pos[u] >= 0));
                check($sformatf("model_ready%0d", u), 32'(rdy_a[u]), 32'(m_pos[u] < 0));
                check($sformatf("model_done%0d", u), 32'(done_a[u]), 32'(m_done[u]));
            end
        end
    end

    task automatic send(input int u, input logic [9:0] d);
        @(negedge clk);
        din_a[u] = d;
        val_a[u] = 1'b1;
        @(negedge clk);
        val_a[u] = 1'b0;
    endtask

    task automatic record(input int n);
        for (int j = 1; j <= n; j++) begin
            for (int u = 0; u < 2; u++) begin
                rtx[u][j] = tx_a[u];
                rdn[u][j] = done_a[u];
                rbs[u][j] = busy_a[u];
            end
            @(negedge clk);
        end
    endtask

    // seq[i] is the i-th data bit on the line; index j is cycle k+j after accept edge k.
    task automatic check_frame(input int u, input string nm, input logic [9:0] seq, input int c);
        int l;
        int bad;
        l = 12 * c;
        bad = 0;
        for (int j = 1; j <= c; j++) if (rtx[u][j] !== 1'b0) bad++;
        check({nm, "_start_bad_cycles"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 10; i++)
            for (int m = 0; m < c; m++) if (rtx[u][1+(1+i)*c+m] !== seq[i]) bad++;
        check({nm, "_data_bad_cycles"}, bad, 0);
        bad = 0;
        for (int j = 11 * c + 1; j <= l; j++) if (rtx[u][j] !== 1'b1) bad++;
        check({nm, "_stop_bad_cycles"}, bad, 0);
        bad = 0;
        for (int j = 1; j <= l + 3; j++) if (rdn[u][j] !== (j == l + 1)) bad++;
        check({nm, "_done_bad_cycles"}, bad, 0);
        bad = 0;
        for (int j = 1; j <= l + 1; j++) if (rbs[u][j] !== (j <= l)) bad++;
        check({nm, "_busy_bad_cycles"}, bad, 0);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            din_a[u] = '0;
            val_a[u] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("idle_tx", 32'(tx_a[0]), 1);
            check("idle_busy", 32'(busy_a[0]), 0);
            check("idle_done", 32'(done_a[0]), 0);
            check("idle_ready", 32'(rdy_a[0]), 1);
        end

        send(0, 10'h2A5);
        record(60);
        check_frame(0, "s2", 10'b1010100101, 4);

        @(negedge clk);
        din_a[0] = 10'h3FF;
        val_a[0] = 1'b1;
        @(negedge clk);
        din_a[0] = 10'h000;
        for (int j = 1; j <= 100; j++) begin
            rtx[0][j] = tx_a[0];
            rdn[0][j] = done_a[0];
            rbs[0][j] = busy_a[0];
            if (j == 60) val_a[0] = 1'b0;
            @(negedge clk);
        end
        check_frame(0, "s3a", 10'h3FF, 4);
        check("s3_gap_high", 32'(rtx[0][49]), 1);
        check("s3_second_start", 32'(rtx[0][50]), 0);
        bad = 0;
        for (int j = 54; j <= 93; j++) if (rtx[0][j] !== 1'b0) bad++;
        check("s3_second_data_bad_cycles", bad, 0);
        check("s3_second_done", 32'(rdn[0][98]), 1);
        repeat (4) @(negedge clk);

        send(0, 10'h155);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s4_rst_tx", 32'(tx_a[0]), 1);
        check("s4_rst_busy", 32'(busy_a[0]), 0);
        check("s4_rst_ready", 32'(rdy_a[0]), 1);
        check("s4_rst_done", 32'(done_a[0]), 0);
        bad = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (done_a[0] !== 1'b0) bad++;
        end
        check("s4_no_done_after_abort", bad, 0);
        send(0, 10'h0F0);
        record(60);
        check_frame(0, "s4", 10'h0F0, 4);

        send(0, 10'h2A5);
        for (int j = 1; j <= 60; j++) begin
            rtx[0][j] = tx_a[0];
            rdn[0][j] = done_a[0];
            rbs[0][j] = busy_a[0];
            din_a[0] = (j < 40) ? 10'($urandom) : 10'h000;
            val_a[0] = (j < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        check_frame(0, "s5", 10'b1010100101, 4);

        send(1, 10'h200);
        record(20);
        check_frame(1, "s6", 10'h001, 1);

        for (int j = 0; j < 3000; j++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int u = 0; u < 2; u++) begin
                din_a[u] = 10'($urandom);
                val_a[u] = ($urandom_range(0, 3) != 0);
            end
        end
        reset = 1'b0;
        val_a[0] = 1'b0;
        val_a[1] = 1'b0;
        repeat (60) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_tx_10bit.md
Name: serial_tx_10bit

Overview:
Transmit-side partner of the 10-bit parallel register. It accepts a DATA_W-bit parallel word through a valid/ready handshake and drives it onto a single serial line as a frame: start bit, data bits, stop bit. Each bit is held for CLKS_PER_BIT clocks. It sits between the register stage's output and an off-block serial link, and its frames are consumed by a matching deserializer.

Parameters:
DATA_W, 10, word width in bits (>=1)
CLKS_PER_BIT, 4, clocks each serial bit is held (>=1)
MSB_FIRST, 0, 0 = transmit din[0] first; 1 = transmit din[DATA_W-1] first

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
din  input  DATA_W  parallel word to transmit
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line; idles high
busy  output  1  frame in progress (START/DATA/STOP)
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Interface clocking: reset is synchronous, active-high; clock is clk.
- Reset values: tx_out=1, busy=0, done=0, din_ready=1, state=IDLE, shift register=0, bit and clock counters=0.
- tx_out, busy and done are registered. din_ready is decoded from state: 1 only in IDLE.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx_out=1.
  - Accept occurs at the edge where din_valid && din_ready: din is captured into the shift register and the FSM moves to START.
  - If din_valid=0, the FSM stays in IDLE.
- Timing from an accept at edge k (C = CLKS_PER_BIT):
  - Cycles k+1 .. k+C: START, tx_out=0, busy=1.
  - Data bit i (i = 0..DATA_W-1) occupies cycles k+1+(1+i)*C .. k+(2+i)*C.
  - Bit order: LSB first when MSB_FIRST=0; MSB first when MSB_FIRST=1.
  - STOP occupies the last C cycles, ending at cycle k+(DATA_W+2)*C, with tx_out=1.
  - Cycle k+1+(DATA_W+2)*C: state=IDLE, busy=0, done=1 for exactly one cycle, din_ready=1.
- Frame length is (DATA_W+2)*C cycles.
- Back-to-back: if din_valid is high in the done cycle, that is an accept. The next start bit then begins on the following cycle, so exactly one idle-high cycle separates frames.
- Clock counter: counts 0..C-1 in every non-IDLE state and advances state/bit on reaching C-1. For C=1 every bit lasts one cycle. Bit counter counts 0..DATA_W-1 in DATA.
- din and din_valid are ignored while busy: no capture, and no effect on the frame in flight. The captured word is immune to din changes after the accept.
- Reset mid-frame: on the next cycle tx_out=1, state=IDLE, busy=0, done=0, din_ready=1. The partial frame is abandoned. No done pulse is produced for the aborted frame.
- Reset and din_valid high in the same cycle: reset wins; no word is captured.
- No overflow or underflow conditions exist. The frame is fixed length, and the upstream side must hold din_valid until it sees din_ready.

Test Plan:
1. Idle after reset, din_valid=0 for 20 cycles -> tx_out=1, busy=0, done=0, din_ready=1 throughout.
2. C=4, MSB_FIRST=0, din=10'h2A5, single accept at edge k:
   - tx_out=0 for k+1..k+4.
   - Then bits 1,0,1,0,0,1,0,1,0,1, each held 4 cycles.
   - Then stop high for 4 cycles.
   - done=1 only at cycle k+49.
   - busy=1 for 48 cycles.
3. Back-to-back: din_valid held high with 10'h3FF, then 10'h000 -> second accept in the done cycle; exactly one tx_out=1 cycle between the first stop bit and the second start bit; second frame data is all 0.
4. Reset asserted at data bit 3 of frame 10'h155 -> next cycle tx_out=1, busy=0, din_ready=1, no done pulse; a new accept of 10'h0F0 afterwards transmits correctly.
5. din changed to 10'h000 and din_valid toggled while busy on frame 10'h2A5 -> serial output identical to scenario 2; no extra frame sent.
6. MSB_FIRST=1, C=1, din=10'h200 -> start 0, then data bits 1,0,0,0,0,0,0,0,0,0, then stop 1; done=1 at cycle k+13.
